either_edge_detector: RTL and testbench
=======================================

EITHER_EDGE_DETECTOR -- requirements
Module: either_edge_detector

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range 2..4; any other value SHALL be a static elaboration error.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port din  input  1  level signal, asynchronous to clk; may change at any time, including mid-cycle.
REQ-005 Port either_edge  output  1  registered one-cycle pulse on any change of the synchronized din.
REQ-006 Port order SHALL be clk, rst, din, either_edge so positional instantiation binds correctly.

Function
REQ-007 din SHALL pass through a SYNC_STAGES-deep flop chain, sync[0] first and sync[SYNC_STAGES-1] last, before any logic uses it.
REQ-008 A history flop prev SHALL capture sync[SYNC_STAGES-1] every rising clk edge.
REQ-009 either_edge SHALL be a flop loaded every rising edge with sync[SYNC_STAGES-1] XOR prev; no combinational path SHALL exist from din to either_edge.
REQ-010 Rising and falling transitions SHALL both produce a pulse; polarity SHALL NOT be distinguished.
REQ-011 Latency: if din takes a new value before rising edge k and holds it, either_edge SHALL be 1 from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1 (default: high during the 3rd cycle after the sampling edge).
REQ-012 Each pulse SHALL be exactly one clk cycle wide while din holds its new level.
REQ-013 din toggling on every sampling edge SHALL give one pulse per cycle, i.e. either_edge held high continuously.
REQ-014 din pulses or glitches that begin and end between two rising edges SHALL be ignored with no pulse; there is no requirement to catch sub-cycle activity.
REQ-015 Multiple din changes inside one cycle SHALL be judged only by the level sampled at the edge: net change gives one pulse, no net change gives none.
REQ-016 The design SHALL be free of latches and SHALL contain no combinational feedback.

Reset
REQ-017 While rst=1, sync[*], prev and either_edge SHALL be 0 immediately, without waiting for a clk edge.
REQ-018 After rst falls, operation SHALL resume on the next rising edge. If din=1 at release, the 0-to-1 change seen through the chain SHALL produce exactly one pulse at the normal latency.
REQ-019 rst asserted mid-pulse or mid-synchronization SHALL abort it: either_edge goes to 0 at once, and no pulse from pre-reset activity SHALL appear after release.

Verification (clk period 40 time units, SYNC_STAGES=2)
REQ-020 Hold rst=1, din=0 for 60; toggle din during reset -> either_edge stays 0 throughout; stays 0 after release while din=0.
REQ-021 Release reset, set din 0->1 before edge k and hold 200 -> exactly one 40-wide pulse, high between edges k+2 and k+3; repeat with din 1->0 -> identical single pulse.
REQ-022 din high for 3 units entirely between two rising edges, then low -> no pulse.
REQ-023 din toggling each cycle, changes placed mid-cycle -> either_edge continuously 1 starting 2 edges after the first change, falling 3 edges after the toggling stops.
REQ-024 din=1 at reset release -> one pulse at edge 3 after release; assert rst while either_edge=1 -> output drops to 0 asynchronously and no further pulse follows.
REQ-025 Random din changes at irregular offsets (3..90 units) for 2800 units -> pulse count equals the number of level changes of din sampled at rising edges, each with the REQ-011 latency.

Source files
------------

// File: rtl/either_edge_detector_if.sv
// -----------------------------------------------------------------------------
// either_edge_detector_if
//
// Bundles the level input and the edge pulse output of the either-edge
// detector so an environment can carry both as one object.
//
//   din          level signal, asynchronous to the detector clock
//   either_edge  one-cycle pulse on every change of the synchronized din
//
// Modports:
//   master  drives din, observes either_edge (the stimulus / producer side)
//   slave   observes din, drives either_edge (the detector side)
// -----------------------------------------------------------------------------
interface either_edge_detector_if;
    logic din;
    logic either_edge;

    modport master (
        output din,
        input  either_edge
    );

    modport slave (
        input  din,
        output either_edge
    );
endinterface : either_edge_detector_if

// File: rtl/either_edge_detector.sv
// -----------------------------------------------------------------------------
// either_edge_detector
//
// Brings an asynchronous level signal into the clk domain through a
// SYNC_STAGES-deep synchronizer, then emits a registered one-cycle pulse
// whenever the synchronized level changes in either direction.
//
// Parameters:
//   SYNC_STAGES  depth of the input synchronizer, 2..4 (default 2)
//
// Ports (kept as plain scalars in this order so positional binding works):
//   clk          rising-edge clock for all state
//   rst          asynchronous, active-high reset; clears every flop at once
//   din          asynchronous level input
//   either_edge  registered pulse, high for one cycle per synchronized change
//
// Latency: a new din level sampled at rising edge k shows up on either_edge
// from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1.
// -----------------------------------------------------------------------------
module either_edge_detector #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic either_edge
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("either_edge_detector: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   either_edge_q;
    logic                   either_edge_d;

    // Synchronizer chain: din enters at bit 0 and walks towards the top bit.
    // Only the top bit is ever used by logic downstream.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // History and edge compare: prev holds last cycle's synchronized level,
    // so the XOR is high for exactly the cycle in which the level differs.
    // The XOR result is registered, keeping din off any combinational path
    // to the output.
    always_comb begin
        prev_d        = sync_q[SYNC_STAGES-1];
        either_edge_d = sync_q[SYNC_STAGES-1] ^ prev_q;
    end

    // Asynchronous clear aborts any pulse or in-flight synchronization the
    // moment rst rises; nothing captured before reset can surface afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= '0;
            prev_q        <= 1'b0;
            either_edge_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            either_edge_q <= either_edge_d;
        end
    end

    assign either_edge = either_edge_q;

endmodule : either_edge_detector

// File: tb/tb_either_edge_detector.sv
module tb_either_edge_detector;

    localparam int SS     = 2;
    localparam int HALF   = 20;
    localparam int PERIOD = 2 * HALF;

    logic clk;
    logic rst;

    either_edge_detector_if ifc ();

    either_edge_detector #(
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (ifc.din),
        .either_edge(ifc.either_edge)
    );

    int   checks = 0;
    int   errors = 0;

    bit   exp_q[$];      // expected either_edge, one entry per rising edge
    bit   samp[$];       // din levels sampled at rising edges since reset

    bit   rnd_phase = 1'b0;
    int   model_changes = 0;
    int   dut_highs = 0;

    int   req_mode = 0;  // 0 scoreboard, 1 reset-clear check, 2 pulse-count check
    event req_ev;

    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    // Reference model: the output after edge n equals "did the level sampled
    // SS edges ago differ from the one sampled SS+1 edges ago". Samples before
    // reset release count as 0; while in reset the output is 0.
    always @(posedge clk) begin
        int n;
        bit a;
        bit b;
        bit last;
        if (rst) begin
            samp.delete();
            exp_q.push_back(1'b0);
        end else begin
            last = (samp.size() > 0) ? samp[samp.size()-1] : 1'b0;
            if (rnd_phase && (last != ifc.din)) model_changes++;
            samp.push_back(ifc.din);
            n = samp.size();
            a = (n - 1 - SS >= 0) ? samp[n-1-SS] : 1'b0;
            b = (n - 2 - SS >= 0) ? samp[n-2-SS] : 1'b0;
            exp_q.push_back(a ^ b);
        end
    end

    // Monitor: pops one expectation per cycle on the falling edge, and also
    // serves on-demand checks requested by the stimulus between edges.
    initial begin
        bit e;
        forever begin
            @(negedge clk or req_ev);
            if (req_mode == 1) begin
                checks++;
                if (ifc.either_edge !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset_clear t=%0t got %b expected 0", $time, ifc.either_edge);
                end
            end else if (req_mode == 2) begin
                checks++;
                if (dut_highs != model_changes) begin
                    errors++;
                    $display("FAIL pulse_count got %0d expected %0d", dut_highs, model_changes);
                end
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got %b expected <entry>", $time, ifc.either_edge);
                end else begin
                    e = exp_q.pop_front();
                    if (ifc.either_edge !== e) begin
                        errors++;
                        $display("FAIL either_edge t=%0t got %b expected %b", $time, ifc.either_edge, e);
                    end
                end
                if (rnd_phase && ifc.either_edge === 1'b1) dut_highs++;
            end
        end
    end

    task automatic request(input int mode);
        req_mode = mode;
        ->req_ev;
        #1;
        req_mode = 0;
    endtask

    initial begin
        int d;
        longint t0;

        rst     = 1'b1;
        ifc.din = 1'b0;

        // Toggling din under reset must not leak through.
        #15 ifc.din = 1'b1;
        #12 ifc.din = 1'b0;
        #10 ifc.din = 1'b1;
        #13 ifc.din = 1'b0;
        request(1);
        #19 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Single rising change, then single falling change.
        @(posedge clk);
        #10 ifc.din = 1'b1;
        #200 ifc.din = 1'b0;
        #200;

        // Sub-cycle glitch between two edges.
        @(posedge clk);
        #10 ifc.din = 1'b1;
        #3  ifc.din = 1'b0;
        repeat (4) @(posedge clk);

        // Toggle every cycle at mid-cycle.
        @(negedge clk);
        repeat (10) begin
            ifc.din = ~ifc.din;
            @(negedge clk);
        end
        ifc.din = 1'b0;
        repeat (6) @(posedge clk);

        // Reset with din high, release with din high -> one pulse at edge 3.
        @(negedge clk);
        #5 rst = 1'b1;
        ifc.din = 1'b1;
        #1 request(1);
        @(posedge clk);
        #10 rst = 1'b0;
        repeat (3) @(posedge clk);
        // Pulse is high now; abort it with reset.
        @(negedge clk);
        #5 rst = 1'b1;
        #1 request(1);
        ifc.din = 1'b0;
        #50;
        @(posedge clk);
        #10 rst = 1'b0;
        repeat (6) @(posedge clk);

        // Random changes at irregular offsets; count highs against changes.
        @(negedge clk);
        #5 rnd_phase = 1'b1;
        t0 = $time;
        while ($time - t0 < 2800) begin
            d = int'($urandom_range(3, 90));
            if ((($time + d) % PERIOD) == HALF) d++;
            #d ifc.din = ~ifc.din;
        end
        repeat (6) @(negedge clk);
        #5 rnd_phase = 1'b0;
        request(2);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_either_edge_detector
